// File: rtl/env_sched_pkg.sv
// Shared types for the envelope scheduler: scan FSM encoding, per-oscillator
// state record and the saturating gain accumulator.
package env_sched_pkg;

   import protocol_pkg::*;

   localparam int STAGE_W = $clog2(ENVELOPE_LEN + 1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SCAN = 1'b1
   } sched_state_e;

   typedef struct packed {
      logic [STAGE_W-1:0] stage;
      logic [31:0]        remaining;
      logic [31:0]        gain;
   } env_state_t;

   // Unsigned gain plus signed rate, clamped to [0, 2^32-1] using 34-bit headroom.
   function automatic logic [31:0] sat_add(input logic [31:0] gain, input logic [31:0] rate);
      logic [33:0] sum;
      sum = {2'b00, gain} + {{2{rate[31]}}, rate};
      if (sum[33]) begin
         sat_add = 32'd0;
      end else if (sum[32]) begin
         sat_add = 32'hFFFF_FFFF;
      end else begin
         sat_add = sum[31:0];
      end
   endfunction

endpackage

// File: rtl/protocol_pkg.sv
// Configuration types written by the MCU and decoded by the protocol receiver.
// Envelope lists are stored per oscillator as packed (rate, duration) pairs.
`ifndef N_OSCILLATORS
`define N_OSCILLATORS 4
`endif
`ifndef ENVELOPE_LEN
`define ENVELOPE_LEN 3
`endif

package protocol_pkg;

   localparam int N_OSCILLATORS = `N_OSCILLATORS;
   localparam int ENVELOPE_LEN  = `ENVELOPE_LEN;

   typedef struct packed {
      logic [31:0] rate;
      logic [31:0] duration;
   } envelope_t;

   typedef struct packed {
      envelope_t [N_OSCILLATORS-1:0][ENVELOPE_LEN-1:0] envelopes;
   } synth_t;

endpackage

// File: rtl/envelope_step.sv
// Combinational single-oscillator envelope update: restart, hold, stage advance
// and saturating gain ramp for one sample tick.
module envelope_step
   import protocol_pkg::*;
   import env_sched_pkg::*;
#(
   parameter int ENV_LEN = ENVELOPE_LEN
) (
   input  env_state_t               cur,
   input  logic                     pending,
   input  envelope_t [ENV_LEN-1:0]  envs,
   output env_state_t               nxt,
   output logic [31:0]              gain
);

   localparam logic [STAGE_W-1:0] DONE = STAGE_W'(ENV_LEN);

   logic [STAGE_W-1:0] adv_stage_s;
   logic [31:0]        adv_dur_s;
   logic [31:0]        cur_rate_s;
   logic [31:0]        dec_rem_s;
   logic [31:0]        acc_gain_s;

   // Look up the current rate and the duration of the following stage (0 once past the end).
   always_comb begin
      adv_stage_s = cur.stage + STAGE_W'(1);
      adv_dur_s   = 32'd0;
      cur_rate_s  = 32'd0;
      for (int k = 0; k < ENV_LEN; k++) begin
         adv_dur_s  = (adv_stage_s == STAGE_W'(k)) ? envs[k].duration : adv_dur_s;
         cur_rate_s = (cur.stage == STAGE_W'(k)) ? envs[k].rate : cur_rate_s;
      end
      dec_rem_s  = cur.remaining - 32'd1;
      acc_gain_s = sat_add(cur.gain, cur_rate_s);
   end

   // Priority: restart, finished hold, zero-duration skip, ramp.
   always_comb begin
      nxt  = cur;
      gain = cur.gain;
      if (pending) begin
         nxt.gain      = 32'd0;
         nxt.stage     = '0;
         nxt.remaining = envs[0].duration;
         gain          = 32'd0;
      end else if (cur.stage == DONE) begin
         nxt  = cur;
         gain = cur.gain;
      end else if (cur.remaining == 32'd0) begin
         nxt.stage     = adv_stage_s;
         nxt.remaining = adv_dur_s;
      end else begin
         nxt.gain = acc_gain_s;
         gain     = acc_gain_s;
         if (dec_rem_s == 32'd0) begin
            nxt.stage     = adv_stage_s;
            nxt.remaining = adv_dur_s;
         end else begin
            nxt.remaining = dec_rem_s;
         end
      end
   end

endmodule

// File: rtl/envelope_scheduler.sv
// Time-multiplexed envelope sequencer: one oscillator per clock after each
// sample tick, streaming post-step gains to the amplitude/mixer datapath.
`ifndef N_OSCILLATORS
`define N_OSCILLATORS 4
`endif
`ifndef ENVELOPE_LEN
`define ENVELOPE_LEN 3
`endif

module envelope_scheduler
   import protocol_pkg::*;
   import env_sched_pkg::*;
#(
   parameter int N_OSC   = `N_OSCILLATORS,
   parameter int ENV_LEN = `ENVELOPE_LEN,
   parameter int IDX_W   = $clog2(N_OSC)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               sample_tick,
   input  synth_t             synth,
   input  logic [N_OSC-1:0]   note_on,
   output logic [31:0]        gain_out,
   output logic [IDX_W-1:0]   gain_idx,
   output logic               gain_valid,
   output logic               busy,
   output logic [N_OSC-1:0]   active,
   output logic               overrun
);

   localparam logic [0:0]         ST_IDLE = IDLE;
   localparam logic [0:0]         ST_SCAN = SCAN;
   localparam logic [STAGE_W-1:0] DONE    = STAGE_W'(ENV_LEN);
   localparam logic [IDX_W-1:0]   LAST    = IDX_W'(N_OSC - 1);

   logic [0:0]       state_r;
   logic [IDX_W-1:0] idx_r;
   env_state_t       st_r [N_OSC];
   logic [N_OSC-1:0] pending_r;
   logic             scanning_s;
   env_state_t       cur_s;
   env_state_t       nxt_s;
   logic [31:0]      step_gain_s;
   logic [N_OSC-1:0] clr_s;
   logic [N_OSC-1:0] active_s;

   assign scanning_s = (state_r == ST_SCAN);
   assign busy       = scanning_s;
   assign cur_s      = st_r[idx_r];

   envelope_step #(
      .ENV_LEN (ENV_LEN)
   ) u_step (
      .cur     (cur_s),
      .pending (pending_r[idx_r]),
      .envs    (synth.envelopes[idx_r]),
      .nxt     (nxt_s),
      .gain    (step_gain_s)
   );

   // Pending clear mask for the oscillator in its processing cycle, and live stage status.
   always_comb begin
      clr_s    = '0;
      active_s = '0;
      for (int i = 0; i < N_OSC; i++) begin
         clr_s[i]    = scanning_s && (idx_r == IDX_W'(i));
         active_s[i] = (st_r[i].stage != DONE);
      end
   end

   // Scan FSM, per-oscillator state, note_on capture and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         idx_r      <= '0;
         pending_r  <= '0;
         gain_out   <= 32'd0;
         gain_idx   <= '0;
         gain_valid <= 1'b0;
         active     <= '0;
         overrun    <= 1'b0;
         for (int i = 0; i < N_OSC; i++) begin
            st_r[i].stage     <= DONE;
            st_r[i].remaining <= 32'd0;
            st_r[i].gain      <= 32'd0;
         end
      end else begin
         // A note_on coinciding with the oscillator's own slot survives the clear.
         pending_r  <= note_on | (pending_r & ~clr_s);
         active     <= active_s;
         gain_valid <= scanning_s;
         gain_idx   <= scanning_s ? idx_r : '0;
         gain_out   <= scanning_s ? step_gain_s : 32'd0;
         case (state_r)
            ST_IDLE: begin
               if (sample_tick) begin
                  state_r <= ST_SCAN;
                  idx_r   <= '0;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_SCAN: begin
               st_r[idx_r] <= nxt_s;
               if (sample_tick) begin
                  overrun <= 1'b1;
               end else begin
                  overrun <= overrun;
               end
               if (idx_r == LAST) begin
                  state_r <= ST_IDLE;
                  idx_r   <= '0;
               end else begin
                  idx_r   <= idx_r + IDX_W'(1);
               end
            end
            default: begin
               state_r <= ST_IDLE;
               idx_r   <= '0;
            end
         endcase
      end
   end

endmodule

// File: doc/envelope_scheduler.md
Name: envelope_scheduler

Overview:
- Time-multiplexed sequencer that walks every oscillator's `envelope_t` list from the MCU-written `synth_t` configuration.
- Once per audio sample it scans all oscillators, one per clock. For each it advances the stage/duration counters and updates a saturating 32-bit gain.
- Emits the gains as an indexed stream to the shared amplitude/mixer datapath.
- Sits between the protocol receiver (source of `synth_t`) and the wave generators.

Parameters:
- N_OSC, default `N_OSCILLATORS: number of oscillators scanned.
- ENV_LEN, default `ENVELOPE_LEN: envelope stages per oscillator.
- IDX_W, default $clog2(N_OSC): width of the oscillator index.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- sample_tick  in  1  one-cycle pulse at the sample rate; starts a scan.
- synth  in  $bits(synth_t)  live configuration; read per oscillator in its processing cycle.
- note_on  in  N_OSC  one-cycle pulses; restart that oscillator's envelope.
- gain_out  out  32  unsigned gain of oscillator gain_idx.
- gain_idx  out  IDX_W  oscillator index of gain_out.
- gain_valid  out  1  gain_out/gain_idx valid this cycle.
- busy  out  1  scan in progress.
- active  out  N_OSC  oscillator stage < ENV_LEN.
- overrun  out  1  sticky: sample_tick arrived while busy.

Behaviour:
- Reset (also mid-scan, which aborts the scan):
  - FSM = IDLE.
  - Per oscillator: stage = ENV_LEN (done), remaining = 0, gain = 0.
  - pending = 0.
  - All outputs 0.
- FSM states and transitions:
  - IDLE: sample_tick -> SCAN, idx = 0.
  - SCAN: processes idx each cycle; idx == N_OSC-1 -> IDLE, else idx + 1.
- busy = (state == SCAN).
- Timing for a tick at cycle T:
  - oscillator i is processed in cycle T+1+i;
  - registered outputs show it at T+2+i with gain_valid = 1;
  - gain_valid = 0 otherwise.
- Minimum tick spacing is N_OSC+1 cycles.
- sample_tick while in SCAN: ignored (no extra scan); sets overrun, which stays set until reset.
- note_on: ORed into a pending register. When an oscillator is processed, its pending bit is cleared unless note_on for it is asserted in the same cycle (set wins over clear).
- Per-oscillator step, in its processing cycle, first matching rule wins:
  1. pending: gain = 0, stage = 0, remaining = envelopes[0].duration; output 0.
  2. stage == ENV_LEN: hold gain; output it.
  3. remaining == 0 (zero-duration stage): stage + 1; load remaining from envelopes[stage+1].duration, or 0 if the new stage == ENV_LEN; gain unchanged.
  4. Otherwise:
     - gain = clamp(gain + signed(rate), 0, 2^32-1), computed in 34 bits;
     - remaining - 1;
     - if the result is 0, advance stage and load the next duration in the same cycle.
- Output value: gain_out carries the post-step gain.
- Width of `duration`: full 32 bits; it counts sample ticks.
- A zero-duration stage consumes one tick and applies no rate.
- active[i] is a registered copy of (stage[i] != ENV_LEN).

Decomposition:
- Add to a shared package `env_sched_pkg`:
  - enum sched_state_e {IDLE, SCAN};
  - packed struct env_state_t {stage, remaining[31:0], gain[31:0]}.
- Both import `protocol_pkg` for `envelope_t`/`synth_t`.
- Per-oscillator state is held in registers (or an N_OSC-deep RAM).
- Sub-module `envelope_step`: purely combinational. Inputs are env_state_t, the pending bit and the oscillator's envelope array; outputs are the next env_state_t and the output gain. It holds all clamp and stage-advance logic.

Test Plan:
Bench uses N_OSCILLATORS = 4, ENVELOPE_LEN = 3.
1. Reset, then two ticks 10 cycles apart -> each gives 4 gain_valid pulses, idx 0,1,2,3, all gains 0; active = 0; busy high exactly 4 cycles.
2. Oscillator 1 programmed with env0 {rate 0x1000_0000, duration 3}, env1 {0xF800_0000, 2}, env2 {0, 0}; note_on[1], then 7 ticks -> oscillator 1 gains: 0, 0x1000_0000, 0x2000_0000, 0x3000_0000, 0x2800_0000, 0x2000_0000, 0x2000_0000. active[1] is 1 through tick 6 and 0 after tick 7.
3. Clamp: env0 {0x7FFF_FFFF, 3} -> 0x7FFF_FFFF, 0xFFFF_FFFE, 0xFFFF_FFFF. Then env1 {0xC000_0000, 2} -> 0xBFFF_FFFF, 0x7FFF_FFFF. Floor check: gain 0x2000_0000 with rate 0xC000_0000 -> 0.
4. Ticks at T and T+2 -> exactly 4 gain_valid pulses; overrun = 1 and remains 1 across later ticks until reset.
5. note_on[2] asserted in oscillator 2's processing cycle -> this scan outputs the unrestarted gain; the next scan outputs 0 with stage 0 loaded.
6. reset asserted at T+3 during a scan -> next cycle gain_valid = 0, busy = 0, active = 0, overrun = 0; the following tick scans normally with all gains 0.
